// File: rtl/pixel_stream_packer.sv
// Packs PIX_PER_BEAT shades per output word, buffers words in a FWFT FIFO and
// frames them with sof/eol/eof. Shades offered while in_ready is low are counted.
module pixel_stream_packer #(
  parameter int COLOR_WIDTH  = 8,
  parameter int PIX_PER_BEAT = 4,
  parameter int IMG_W        = 640,
  parameter int IMG_H        = 480,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sync_clr,
  input  logic [COLOR_WIDTH-1:0]              shade_in,
  input  logic                                valid_in,
  output logic                                in_ready,
  output logic [PIX_PER_BEAT*COLOR_WIDTH-1:0] out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                sof,
  output logic                                eol,
  output logic                                eof_pulse,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
  output logic [15:0]                         drop_count
);

  localparam int WORD_W = PIX_PER_BEAT * COLOR_WIDTH;
  localparam int LANE_W = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
  localparam int NREG   = (PIX_PER_BEAT > 1) ? PIX_PER_BEAT - 1 : 1;
  localparam int X_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int Y_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(PIX_PER_BEAT - 1);
  localparam logic [X_W-1:0]    X_LAST    = X_W'(IMG_W - 1);
  localparam logic [X_W-1:0]    X_FIRST_W = X_W'(PIX_PER_BEAT - 1);
  localparam logic [Y_W-1:0]    Y_LAST    = Y_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  logic [LANE_W-1:0] lane_reg, lane_next;
  logic [X_W-1:0]    x_reg, x_next;
  logic [Y_W-1:0]    y_reg, y_next;
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              eof_reg, eof_next;
  logic [15:0]       drop_cnt_reg;

  logic [COLOR_WIDTH-1:0] lane_data_reg [NREG];
  logic [WORD_W-1:0]      mem_data [FIFO_DEPTH];
  logic                   mem_sof  [FIFO_DEPTH];
  logic                   mem_eol  [FIFO_DEPTH];
  logic [Y_W-1:0]         mem_y    [FIFO_DEPTH];

  logic              fifo_full, fifo_empty, accept, push, pop, drop;
  logic              word_sof, word_eol;
  logic [WORD_W-1:0] word_in;

  assign fifo_full  = (count_reg == CNT_FULL);
  assign fifo_empty = (count_reg == '0);
  // Only the word-completing lane needs a free slot, so earlier lanes keep flowing when full.
  assign in_ready   = !((lane_reg == LANE_LAST) && fifo_full);
  assign accept     = valid_in && in_ready && !sync_clr;
  assign push       = accept && (lane_reg == LANE_LAST);
  assign pop        = !fifo_empty && out_ready;
  assign drop       = valid_in && !in_ready;

  // Word tags are derived from the coordinate of the pixel in the top lane.
  assign word_sof = (y_reg == '0) && (x_reg == X_FIRST_W);
  assign word_eol = (x_reg == X_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < PIX_PER_BEAT - 1; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (accept && (lane_reg == LANE_W'(gi)))
          lane_data_reg[gi] <= shade_in;
      end
      assign word_in[gi*COLOR_WIDTH +: COLOR_WIDTH] = lane_data_reg[gi];
    end
  endgenerate
  assign word_in[WORD_W-1 -: COLOR_WIDTH] = shade_in;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr_reg] <= word_in;
      mem_sof[wr_ptr_reg]  <= word_sof;
      mem_eol[wr_ptr_reg]  <= word_eol;
      mem_y[wr_ptr_reg]    <= y_reg;
    end
  end

  always_comb begin
    lane_next   = lane_reg;
    x_next      = x_reg;
    y_next      = y_reg;
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    eof_next    = pop && mem_eol[rd_ptr_reg] && (mem_y[rd_ptr_reg] == Y_LAST);
    if (accept) begin
      lane_next = (lane_reg == LANE_LAST) ? '0 : lane_reg + LANE_W'(1);
      if (x_reg == X_LAST) begin
        x_next = '0;
        y_next = (y_reg == Y_LAST) ? '0 : y_reg + Y_W'(1);
      end else begin
        x_next = x_reg + X_W'(1);
      end
    end
    if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
    if (push && !pop)      count_next = count_reg + CNT_W'(1);
    else if (!push && pop) count_next = count_reg - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_reg   <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      eof_reg    <= 1'b0;
    end else if (sync_clr) begin
      lane_reg   <= '0;
      x_reg      <= '0;
      y_reg      <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      eof_reg    <= 1'b0;
    end else begin
      lane_reg   <= lane_next;
      x_reg      <= x_next;
      y_reg      <= y_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
      eof_reg    <= eof_next;
    end
  end

  // Survives sync_clr so drop statistics span frame restarts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_cnt_reg <= '0;
    else if (drop && (drop_cnt_reg != 16'hFFFF))
      drop_cnt_reg <= drop_cnt_reg + 16'd1;
  end

  assign out_valid  = !fifo_empty;
  assign out_data   = mem_data[rd_ptr_reg];
  assign sof        = !fifo_empty && mem_sof[rd_ptr_reg];
  assign eol        = !fifo_empty && mem_eol[rd_ptr_reg];
  assign eof_pulse  = eof_reg;
  assign fifo_level = count_reg;
  assign drop_count = drop_cnt_reg;

endmodule
